// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit word type, transmit-buffer FSM states,
// and the serializer word width.
package uart_pkg;

   localparam int UART_WORD_W = 9;

   typedef logic [UART_WORD_W-1:0] uart_word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      BUSY = 2'd2
   } tx_buf_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data, registered occupancy flags and
// a synchronous flush. A push is refused when full, a pop is refused when
// empty, and flush overrides both in the cycle it is asserted.
module sync_fifo #(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = 9,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             r_full;
   logic             r_empty;
   logic [WIDTH-1:0] r_rdData;

   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_countNext;

   assign w_push = wr_en && !r_full && !flush;
   assign w_pop  = rd_en && !r_empty && !flush;

   // Next occupancy: flush empties the queue, otherwise push and pop cancel.
   always_comb begin
      w_countNext = r_count;
      if (flush) begin
         w_countNext = '0;
      end else if (w_push && !w_pop) begin
         w_countNext = r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
         w_countNext = r_count - CNT_ONE;
      end
   end

   // Read and write pointers, wrapping at DEPTH and cleared by flush.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else if (flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= (r_wrPtr == PTR_LAST) ? '0 : r_wrPtr + PTR_ONE;
         end
         if (w_pop) begin
            r_rdPtr <= (r_rdPtr == PTR_LAST) ? '0 : r_rdPtr + PTR_ONE;
         end
      end
   end

   // Storage array; contents need no reset because the flags gate every read.
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= wr_data;
      end
   end

   // Registered head word, updated only on a pop so it holds between pops.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdData <= '0;
      end else if (w_pop) begin
         r_rdData <= r_mem[r_rdPtr];
      end
   end

   // Occupancy and flags registered together from the next count.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         r_count <= w_countNext;
         r_full  <= (w_countNext == CNT_FULL);
         r_empty <= (w_countNext == '0);
      end
   end

   assign rd_data = r_rdData;
   assign count   = r_count;
   assign full    = r_full;
   assign empty   = r_empty;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit queue in front of the uart_tx serializer. Words are buffered in a
// FIFO and handed to uart_tx one at a time through its send/data/ready
// handshake. tx_send is a registered pulse that never depends
// combinationally on tx_ready, since uart_tx drops ready while send is high.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter  int DEPTH = 16,
   parameter  int WIDTH = UART_WORD_W,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             flush,
   input  logic             clear_overflow,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             tx_send,
   output logic [WIDTH-1:0] tx_data,
   input  logic             tx_ready
);

   tx_buf_state_t    r_state;
   tx_buf_state_t    w_stateNext;
   logic             r_txSend;
   logic             r_overflow;
   logic             w_pop;
   logic             w_sendNext;
   logic             w_fifoFull;
   logic             w_fifoEmpty;
   logic [CNT_W-1:0] w_fifoCount;
   logic [WIDTH-1:0] w_fifoData;

   // The FIFO's registered read port doubles as the tx_data holding register.
   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (w_pop),
      .rd_data (w_fifoData),
      .flush   (flush),
      .count   (w_fifoCount),
      .full    (w_fifoFull),
      .empty   (w_fifoEmpty)
   );

   // Handshake state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next state: launch from IDLE, one SEND cycle, then wait in BUSY for ready.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (!w_fifoEmpty && tx_ready && !flush) begin
               w_stateNext = SEND;
            end
         end
         SEND: begin
            w_stateNext = BUSY;
         end
         BUSY: begin
            if (tx_ready) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Pop the head when leaving IDLE, and request the send pulse for SEND.
   always_comb begin
      w_pop      = 1'b0;
      w_sendNext = 1'b0;
      if (r_state == IDLE && !w_fifoEmpty && tx_ready && !flush) begin
         w_pop      = 1'b1;
         w_sendNext = 1'b1;
      end
   end

   // Registered single-cycle send pulse aligned with the SEND state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_txSend <= 1'b0;
      end else begin
         r_txSend <= w_sendNext;
      end
   end

   // Sticky overflow: a push against a full queue sets it and beats a clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (wr_en && w_fifoFull) begin
         r_overflow <= 1'b1;
      end else if (clear_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign full     = w_fifoFull;
   assign empty    = w_fifoEmpty;
   assign count    = w_fifoCount;
   assign overflow = r_overflow;
   assign tx_send  = r_txSend;
   assign tx_data  = w_fifoData;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: directed scenarios plus randomized traffic,
// with every cycle compared against a queue-based reference model and a
// simple uart_tx stand-in that holds ready low for a frame after each send.
module tb_uart_tx_buffer;

   localparam int DEPTH = 16;
   localparam int WIDTH = 9;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             flush = 1'b0;
   logic             clear_overflow = 1'b0;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] count;
   logic             overflow;
   logic             tx_send;
   logic [WIDTH-1:0] tx_data;
   logic             tx_ready;

   int checks = 0;
   int errors = 0;

   logic forceNotReady = 1'b0;
   int   fixedBusy = 0;
   int   busyLeft;
   bit   checkEnable = 1'b0;

   logic [WIDTH-1:0] mq[$];
   bit               mOverflow;
   bit               mTxSend;
   bit               mInFlight;
   logic [WIDTH-1:0] mTxData;
   int               preSize;
   bit               isFull;
   bit               doPop;
   bit               doPush;

   int               pulseCount = 0;
   int               pulseBase;
   logic [WIDTH-1:0] sentLog[$];

   uart_tx_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .flush          (flush),
      .clear_overflow (clear_overflow),
      .full           (full),
      .empty          (empty),
      .count          (count),
      .overflow       (overflow),
      .tx_send        (tx_send),
      .tx_data        (tx_data),
      .tx_ready       (tx_ready)
   );

   always #5 clock = ~clock;

   // uart_tx stand-in: ready drops with send and stays low for a frame time.
   assign tx_ready = !forceNotReady && (busyLeft == 0) && !tx_send;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         busyLeft <= 0;
      end else if (tx_send) begin
         busyLeft <= (fixedBusy > 0) ? fixedBusy : int'($urandom_range(1, 20));
      end else if (busyLeft > 0) begin
         busyLeft <= busyLeft - 1;
      end
   end

   // Reference model: a word queue, a sticky flag and a frame-in-flight flag.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         mq.delete();
         mOverflow = 1'b0;
         mTxSend   = 1'b0;
         mTxData   = '0;
         mInFlight = 1'b0;
      end else begin
         preSize = mq.size();
         isFull  = (preSize == DEPTH);
         doPop   = !mInFlight && (preSize > 0) && tx_ready && !flush;
         doPush  = wr_en && !isFull && !flush;
         if (wr_en && isFull) mOverflow = 1'b1;
         else if (clear_overflow) mOverflow = 1'b0;
         if (flush) begin
            mq.delete();
         end else begin
            if (doPop) mTxData = mq.pop_front();
            if (doPush) mq.push_back(wr_data);
         end
         if (doPop) mInFlight = 1'b1;
         else if (!mTxSend && tx_ready) mInFlight = 1'b0;
         mTxSend = doPop;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Per-cycle comparison against the model, plus a log of issued words.
   always @(negedge clock) begin
      if (checkEnable && !reset) begin
         checkOutput("count", 32'(count), 32'(mq.size()));
         checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
         checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
         checkOutput("overflow", 32'(overflow), 32'(mOverflow));
         checkOutput("tx_send", 32'(tx_send), 32'(mTxSend));
         checkOutput("tx_data", 32'(tx_data), 32'(mTxData));
         if (tx_send) begin
            pulseCount++;
            sentLog.push_back(tx_data);
         end
      end
   end

   task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] data,
                                input logic fl, input logic clr);
      wr_en          = we;
      wr_data        = data;
      flush          = fl;
      clear_overflow = clr;
      @(negedge clock);
   endtask

   task automatic waitIdle(input int maxCycles);
      int n;
      n = 0;
      while (!(mq.size() == 0 && !mInFlight && !tx_send) && n < maxCycles) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0);
         n++;
      end
      if (n >= maxCycles) begin
         checks++;
         errors++;
         $display("[TB] FAIL waitIdle: still busy after %0d cycles, need idle", n);
      end
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not end, need finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [WIDTH-1:0] burst [4];
      burst[0] = 9'h001;
      burst[1] = 9'h002;
      burst[2] = 9'h0FF;
      burst[3] = 9'h100;

      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      checkEnable = 1'b1;

      $display("[TB] reset values");
      checkOutput("rst_empty", 32'(empty), 32'd1);
      checkOutput("rst_count", 32'(count), 32'd0);
      checkOutput("rst_full", 32'(full), 32'd0);
      checkOutput("rst_overflow", 32'(overflow), 32'd0);
      checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
      checkOutput("rst_tx_data", 32'(tx_data), 32'd0);

      $display("[TB] single word latency");
      applyStimulus(1'b1, 9'h1A5, 1'b0, 1'b0);
      checkOutput("single_c1_count", 32'(count), 32'd1);
      checkOutput("single_c1_send", 32'(tx_send), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_c2_send", 32'(tx_send), 32'd1);
      checkOutput("single_c2_data", 32'(tx_data), 32'h1A5);
      checkOutput("single_c2_count", 32'(count), 32'd0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("single_c3_send", 32'(tx_send), 32'd0);
      checkOutput("single_c3_empty", 32'(empty), 32'd1);
      checkOutput("single_c3_hold", 32'(tx_data), 32'h1A5);
      waitIdle(100);

      $display("[TB] burst of four with long frames");
      fixedBusy = 50;
      pulseBase = pulseCount;
      sentLog.delete();
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, burst[i], 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      waitIdle(400);
      checkOutput("burst_pulses", 32'(pulseCount - pulseBase), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < sentLog.size())
            checkOutput("burst_order", 32'(sentLog[i]), 32'(burst[i]));
      end

      $display("[TB] fill to overflow");
      fixedBusy = 0;
      forceNotReady = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(1'b1, 9'(i + 16), 1'b0, 1'b0);
      checkOutput("fill_count16", 32'(count), 32'd16);
      checkOutput("fill_full", 32'(full), 32'd1);
      checkOutput("fill_no_ovf", 32'(overflow), 32'd0);
      applyStimulus(1'b1, 9'h0AA, 1'b0, 1'b0);
      checkOutput("fill_ovf", 32'(overflow), 32'd1);
      checkOutput("fill_count_hold", 32'(count), 32'd16);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      checkOutput("clear_ovf", 32'(overflow), 32'd0);

      $display("[TB] full with pop and push together");
      forceNotReady = 1'b0;
      fixedBusy = 50;
      applyStimulus(1'b1, 9'h1FF, 1'b0, 1'b0);
      checkOutput("popush_count", 32'(count), 32'd15);
      checkOutput("popush_ovf", 32'(overflow), 32'd1);
      checkOutput("popush_send", 32'(tx_send), 32'd1);
      checkOutput("popush_data", 32'(tx_data), 32'd16);

      $display("[TB] flush during a frame");
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      applyStimulus(1'b1, 9'h055, 1'b1, 1'b0);
      checkOutput("flush_count", 32'(count), 32'd0);
      checkOutput("flush_empty", 32'(empty), 32'd1);
      checkOutput("flush_ovf_kept", 32'(overflow), 32'd1);
      pulseBase = pulseCount;
      repeat (80) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("flush_no_send", 32'(pulseCount - pulseBase), 32'd0);
      waitIdle(100);

      $display("[TB] reset during SEND");
      fixedBusy = 0;
      forceNotReady = 1'b1;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 9'(i + 9'h040), 1'b0, 1'b0);
      forceNotReady = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("rsend_send", 32'(tx_send), 32'd1);
      checkOutput("rsend_count", 32'(count), 32'd3);
      #2 reset = 1'b1;
      #1;
      checkOutput("rsend_rst_send", 32'(tx_send), 32'd0);
      checkOutput("rsend_rst_count", 32'(count), 32'd0);
      checkOutput("rsend_rst_empty", 32'(empty), 32'd1);
      checkOutput("rsend_rst_data", 32'(tx_data), 32'd0);
      @(negedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      pulseBase = pulseCount;
      repeat (20) applyStimulus(1'b0, '0, 1'b0, 1'b0);
      checkOutput("rsend_quiet", 32'(pulseCount - pulseBase), 32'd0);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 5) forceNotReady = ~forceNotReady;
         applyStimulus($urandom_range(0, 99) < 45, 9'($urandom),
                       $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
      end
      forceNotReady = 1'b0;
      waitIdle(2000);

      checkEnable = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_buffer.md
Name: uart_tx_buffer

Overview:
Transmit-side queue that sits directly upstream of the uart_tx serializer. Accepts 9-bit words from the core in bursts, stores them in a synchronous FIFO, and drains them one at a time into uart_tx using its send/data/ready handshake. Decouples producer bursts from the ~1 ms-per-frame serial rate and reports full/empty/overflow status.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2.
WIDTH, 9, word width; matches the uart_tx data port.

Ports:
clock  input  1  system clock
reset  input  1  reset, asynchronous, active-high
wr_en  input  1  push wr_data this cycle
wr_data  input  WIDTH  word to enqueue
flush  input  1  synchronous: discard all queued words
clear_overflow  input  1  clears the sticky overflow flag
full  output  1  count == DEPTH
empty  output  1  count == 0
count  output  $clog2(DEPTH+1)  words currently queued
overflow  output  1  sticky: a push was dropped
tx_send  output  1  to uart_tx send; single-cycle pulse
tx_data  output  WIDTH  to uart_tx data; valid while tx_send is high
tx_ready  input  1  from uart_tx ready

Behaviour:
- Reset values: full=0, empty=1, count=0, overflow=0, tx_send=0, tx_data=0; pointers=0; FSM=IDLE.
- All outputs are registered. tx_send never depends combinationally on tx_ready, which avoids a loop because uart_tx deasserts ready combinationally while send is high.
- Push: when wr_en && !full, write at wr_ptr, increment wr_ptr with wrap at DEPTH, count+1 next cycle.
- Push when full: the word is dropped and overflow is set next cycle. This applies even if a pop occurs in the same cycle, since full is evaluated on registered state.
- Pop: only from the FSM in IDLE. Simultaneous push and pop gives count unchanged, both pointers advance.
- FSM states:
  - IDLE: if !empty && tx_ready && !flush, then pop the head into tx_data, set tx_send=1 next cycle, go to SEND. Otherwise stay.
  - SEND: tx_send is high for exactly this one cycle; uart_tx latches tx_data here. Next state is BUSY and tx_send returns to 0.
  - BUSY: wait for tx_ready==1, then go to IDLE. uart_tx is in its START state on entry, so tx_ready is 0 there.
- Latency:
  - Push into an empty queue at cycle N with uart_tx idle: tx_send is high at cycle N+2.
  - Back-to-back words: the next tx_send comes 2 cycles after tx_ready returns high.
- tx_data holds its value after SEND until the next pop.
- flush:
  - Next cycle: pointers=0, count=0, empty=1, full=0.
  - A concurrent wr_en is ignored.
  - An in-flight frame (SEND or BUSY) is not aborted; the FSM completes its normal path.
  - overflow is unaffected by flush.
- clear_overflow: overflow=0 next cycle. If a dropped push occurs in the same cycle, set wins.
- Reset mid-frame: everything returns to reset values immediately. The serial line is the responsibility of uart_tx, which shares the same reset.
- Ordering: strict FIFO, LSB-agnostic; words pass through unmodified.

Decomposition:
- Shared package uart_pkg:
  - typedef uart_word_t = logic [8:0].
  - enum tx_buf_state_t {IDLE, SEND, BUSY}.
  - Constant UART_WORD_W = 9.
- One sub-module: sync_fifo, parameterized by DEPTH and WIDTH. It provides wr_en/wr_data/rd_en/rd_data/flush/count/full/empty, with registered read data available in the pop cycle's following edge.
- uart_tx_buffer contains sync_fifo, the 3-state FSM, and the overflow logic.

Test Plan:
- Single word, uart_tx model idle: push 9'h1A5 at cycle 0 -> tx_send=1 with tx_data=9'h1A5 at cycle 2 only; empty=1 from cycle 3; count goes 0→1→0.
- Burst of 4 words 9'h001, 9'h002, 9'h0FF, 9'h100 with tx_ready held low for 50 cycles per frame -> four tx_send pulses in order, each 2 cycles after tx_ready rises; no pulse while tx_ready=0.
- Fill with tx_ready=0: push 17 words -> full=1 and count=16 after the 16th; the 17th push is dropped, overflow=1. clear_overflow -> overflow=0 next cycle.
- Full + pop + push in the same cycle -> push is dropped, overflow=1, count becomes 15.
- flush with 5 words queued while in BUSY -> count=0 and empty=1 next cycle; the current frame finishes; no further tx_send after tx_ready returns.
- Assert reset for 1 cycle while in SEND with 3 words queued -> tx_send=0, count=0, empty=1 immediately; no tx_send after reset release until a new push.
- Integration with the real uart_tx: two pushed words -> the tx line shows two complete frames (start, 9 data bits LSB first, stop) in order.
